// File: rtl/id_ex_seg_reg.sv
// rtl/id_ex_seg_reg.sv - ID->EX pipeline segment register with stall/flush and bubble counter
module id_ex_seg_reg #(
    parameter int DATA_W = 32,
    parameter int PERF_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              StallE,
    input  logic              FlushE,
    input  logic              ValidD,
    input  logic [DATA_W-1:0] PCD,
    input  logic [DATA_W-1:0] ImmD,
    input  logic [DATA_W-1:0] RegOut1D,
    input  logic [DATA_W-1:0] RegOut2D,
    input  logic [4:0]        Rs1D,
    input  logic [4:0]        Rs2D,
    input  logic [4:0]        RdD,
    input  logic              JalD,
    input  logic              JalrD,
    input  logic              BranchD,
    input  logic              MemToRegD,
    input  logic              LoadNpcD,
    input  logic              AluSrc1D,
    input  logic [2:0]        RegWriteD,
    input  logic [3:0]        MemWriteD,
    input  logic [3:0]        AluContrlD,
    input  logic [1:0]        AluSrc2D,
    output logic              ValidE,
    output logic [DATA_W-1:0] PCE,
    output logic [DATA_W-1:0] ImmE,
    output logic [DATA_W-1:0] RegOut1E,
    output logic [DATA_W-1:0] RegOut2E,
    output logic [4:0]        Rs1E,
    output logic [4:0]        Rs2E,
    output logic [4:0]        RdE,
    output logic              JalE,
    output logic              JalrE,
    output logic              BranchE,
    output logic              MemToRegE,
    output logic              LoadNpcE,
    output logic              AluSrc1E,
    output logic [2:0]        RegWriteE,
    output logic [3:0]        MemWriteE,
    output logic [3:0]        AluContrlE,
    output logic [1:0]        AluSrc2E,
    output logic [PERF_W-1:0] BubbleCntE
);

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] imm;
        logic [DATA_W-1:0] rdata1;
        logic [DATA_W-1:0] rdata2;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic [4:0]        rd;
        logic              jal;
        logic              jalr;
        logic              branch;
        logic              mem_to_reg;
        logic              load_npc;
        logic              alu_src1;
        logic [2:0]        reg_write;
        logic [3:0]        mem_write;
        logic [3:0]        alu_ctrl;
        logic [1:0]        alu_src2;
    } stage_t;

    stage_t            stage_in;
    stage_t            stage_d;
    stage_t            stage_q;
    logic [PERF_W-1:0] bubble_cnt_d;
    logic [PERF_W-1:0] bubble_cnt_q;
    logic              bubble;

    always_comb begin
        stage_in.valid      = ValidD;
        stage_in.pc         = PCD;
        stage_in.imm        = ImmD;
        stage_in.rdata1     = RegOut1D;
        stage_in.rdata2     = RegOut2D;
        stage_in.rs1        = Rs1D;
        stage_in.rs2        = Rs2D;
        stage_in.rd         = RdD;
        stage_in.jal        = JalD;
        stage_in.jalr       = JalrD;
        stage_in.branch     = BranchD;
        stage_in.mem_to_reg = MemToRegD;
        stage_in.load_npc   = LoadNpcD;
        stage_in.alu_src1   = AluSrc1D;
        stage_in.reg_write  = RegWriteD;
        stage_in.mem_write  = MemWriteD;
        stage_in.alu_ctrl   = AluContrlD;
        stage_in.alu_src2   = AluSrc2D;
    end

    // Stall outranks flush so a held instruction is never replaced by a bubble.
    assign bubble = FlushE && !StallE;

    always_comb begin
        stage_d      = stage_q;
        bubble_cnt_d = bubble_cnt_q;
        if (!StallE) begin
            if (FlushE) begin
                stage_d = '0;
                if (bubble_cnt_q != {PERF_W{1'b1}}) begin
                    bubble_cnt_d = bubble_cnt_q + 1'b1;
                end
            end else begin
                stage_d = stage_in;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q      <= '0;
            bubble_cnt_q <= '0;
        end else begin
            stage_q      <= stage_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign ValidE     = stage_q.valid;
    assign PCE        = stage_q.pc;
    assign ImmE       = stage_q.imm;
    assign RegOut1E   = stage_q.rdata1;
    assign RegOut2E   = stage_q.rdata2;
    assign Rs1E       = stage_q.rs1;
    assign Rs2E       = stage_q.rs2;
    assign RdE        = stage_q.rd;
    assign JalE       = stage_q.jal;
    assign JalrE      = stage_q.jalr;
    assign BranchE    = stage_q.branch;
    assign MemToRegE  = stage_q.mem_to_reg;
    assign LoadNpcE   = stage_q.load_npc;
    assign AluSrc1E   = stage_q.alu_src1;
    assign RegWriteE  = stage_q.reg_write;
    assign MemWriteE  = stage_q.mem_write;
    assign AluContrlE = stage_q.alu_ctrl;
    assign AluSrc2E   = stage_q.alu_src2;
    assign BubbleCntE = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_seg_reg.sv
// tb/tb_id_ex_seg_reg.sv - self-checking bench for id_ex_seg_reg
module tb_id_ex_seg_reg;

    localparam int EW = 163;

    logic        clk = 1'b0;
    logic        rst;
    logic        StallE, FlushE, ValidD;
    logic [31:0] PCD, ImmD, RegOut1D, RegOut2D;
    logic [4:0]  Rs1D, Rs2D, RdD;
    logic        JalD, JalrD, BranchD, MemToRegD, LoadNpcD, AluSrc1D;
    logic [2:0]  RegWriteD;
    logic [3:0]  MemWriteD, AluContrlD;
    logic [1:0]  AluSrc2D;

    logic        ValidE;
    logic [31:0] PCE, ImmE, RegOut1E, RegOut2E;
    logic [4:0]  Rs1E, Rs2E, RdE;
    logic        JalE, JalrE, BranchE, MemToRegE, LoadNpcE, AluSrc1E;
    logic [2:0]  RegWriteE;
    logic [3:0]  MemWriteE, AluContrlE;
    logic [1:0]  AluSrc2E;
    logic [15:0] BubbleCntE;

    logic        n_ValidE;
    logic [31:0] n_PCE, n_ImmE, n_RegOut1E, n_RegOut2E;
    logic [4:0]  n_Rs1E, n_Rs2E, n_RdE;
    logic        n_JalE, n_JalrE, n_BranchE, n_MemToRegE, n_LoadNpcE, n_AluSrc1E;
    logic [2:0]  n_RegWriteE;
    logic [3:0]  n_MemWriteE, n_AluContrlE;
    logic [1:0]  n_AluSrc2E;
    logic [3:0]  n_BubbleCntE;

    logic [EW-1:0] exp_e;
    int            exp_cnt16, exp_cnt4;
    int            errors = 0;
    int            checks = 0;

    always #5 clk = ~clk;

    id_ex_seg_reg #(.DATA_W(32), .PERF_W(16)) dut (
        .clk(clk), .rst(rst), .StallE(StallE), .FlushE(FlushE), .ValidD(ValidD),
        .PCD(PCD), .ImmD(ImmD), .RegOut1D(RegOut1D), .RegOut2D(RegOut2D),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .JalD(JalD), .JalrD(JalrD),
        .BranchD(BranchD), .MemToRegD(MemToRegD), .LoadNpcD(LoadNpcD), .AluSrc1D(AluSrc1D),
        .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .AluContrlD(AluContrlD), .AluSrc2D(AluSrc2D),
        .ValidE(ValidE), .PCE(PCE), .ImmE(ImmE), .RegOut1E(RegOut1E), .RegOut2E(RegOut2E),
        .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .JalE(JalE), .JalrE(JalrE),
        .BranchE(BranchE), .MemToRegE(MemToRegE), .LoadNpcE(LoadNpcE), .AluSrc1E(AluSrc1E),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .AluContrlE(AluContrlE), .AluSrc2E(AluSrc2E),
        .BubbleCntE(BubbleCntE)
    );

    id_ex_seg_reg #(.DATA_W(32), .PERF_W(4)) dut_narrow (
        .clk(clk), .rst(rst), .StallE(StallE), .FlushE(FlushE), .ValidD(ValidD),
        .PCD(PCD), .ImmD(ImmD), .RegOut1D(RegOut1D), .RegOut2D(RegOut2D),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .JalD(JalD), .JalrD(JalrD),
        .BranchD(BranchD), .MemToRegD(MemToRegD), .LoadNpcD(LoadNpcD), .AluSrc1D(AluSrc1D),
        .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .AluContrlD(AluContrlD), .AluSrc2D(AluSrc2D),
        .ValidE(n_ValidE), .PCE(n_PCE), .ImmE(n_ImmE), .RegOut1E(n_RegOut1E), .RegOut2E(n_RegOut2E),
        .Rs1E(n_Rs1E), .Rs2E(n_Rs2E), .RdE(n_RdE), .JalE(n_JalE), .JalrE(n_JalrE),
        .BranchE(n_BranchE), .MemToRegE(n_MemToRegE), .LoadNpcE(n_LoadNpcE), .AluSrc1E(n_AluSrc1E),
        .RegWriteE(n_RegWriteE), .MemWriteE(n_MemWriteE), .AluContrlE(n_AluContrlE), .AluSrc2E(n_AluSrc2E),
        .BubbleCntE(n_BubbleCntE)
    );

    function automatic logic [EW-1:0] pack_d();
        return {ValidD, PCD, ImmD, RegOut1D, RegOut2D, Rs1D, Rs2D, RdD, JalD, JalrD, BranchD,
                MemToRegD, LoadNpcD, AluSrc1D, RegWriteD, MemWriteD, AluContrlD, AluSrc2D};
    endfunction

    function automatic logic [EW-1:0] pack_e();
        return {ValidE, PCE, ImmE, RegOut1E, RegOut2E, Rs1E, Rs2E, RdE, JalE, JalrE, BranchE,
                MemToRegE, LoadNpcE, AluSrc1E, RegWriteE, MemWriteE, AluContrlE, AluSrc2E};
    endfunction

    task automatic rand_d();
        ValidD = 1'($urandom); PCD = $urandom; ImmD = $urandom;
        RegOut1D = $urandom; RegOut2D = $urandom;
        Rs1D = 5'($urandom); Rs2D = 5'($urandom); RdD = 5'($urandom);
        JalD = 1'($urandom); JalrD = 1'($urandom); BranchD = 1'($urandom);
        MemToRegD = 1'($urandom); LoadNpcD = 1'($urandom); AluSrc1D = 1'($urandom);
        RegWriteD = 3'($urandom); MemWriteD = 4'($urandom);
        AluContrlD = 4'($urandom); AluSrc2D = 2'($urandom);
    endtask

    task automatic check(input string tag, input logic [EW-1:0] obs, input logic [EW-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Reference: reset clears, stall holds, flush zeroes and counts (saturating), else copy D.
    task automatic step(input string tag);
        if (rst) begin
            exp_e = '0; exp_cnt16 = 0; exp_cnt4 = 0;
        end else if (StallE) begin
            exp_e = exp_e;
        end else if (FlushE) begin
            exp_e = '0;
            if (exp_cnt16 < 65535) exp_cnt16++;
            if (exp_cnt4 < 15) exp_cnt4++;
        end else begin
            exp_e = pack_d();
        end
        @(posedge clk);
        #1;
        check({tag, ".fields"}, pack_e(), exp_e);
        check({tag, ".cnt16"}, EW'(BubbleCntE), EW'(exp_cnt16));
        check({tag, ".cnt4"}, EW'(n_BubbleCntE), EW'(exp_cnt4));
    endtask

    initial begin
        rst = 1'b1; StallE = 1'b0; FlushE = 1'b0;
        rand_d();
        exp_e = '0; exp_cnt16 = 0; exp_cnt4 = 0;

        step("reset0"); rand_d(); StallE = 1'b1; FlushE = 1'b1;
        step("reset1");

        rst = 1'b0; StallE = 1'b0; FlushE = 1'b0;
        rand_d();
        ValidD = 1'b1; PCD = 32'h100; ImmD = 32'h10; RdD = 5'd5; RegWriteD = 3'd2;
        AluContrlD = 4'd3; MemWriteD = 4'd0; JalD = 1'b0; JalrD = 1'b0; BranchD = 1'b0;
        step("addi");
        check("addi.valid", EW'(ValidE), EW'(1));
        check("addi.rd", EW'(RdE), EW'(5));
        check("addi.pc", EW'(PCE), EW'(32'h100));

        StallE = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_d();
            step("stall");
        end
        check("stall.pc", EW'(PCE), EW'(32'h100));

        StallE = 1'b0; FlushE = 1'b1;
        rand_d(); ValidD = 1'b1; MemWriteD = 4'b1111; RegWriteD = 3'd0;
        step("flush_sw");
        check("flush_sw.memwrite", EW'(MemWriteE), EW'(0));
        check("flush_sw.cnt", EW'(BubbleCntE), EW'(1));

        FlushE = 1'b0; rand_d(); ValidD = 1'b1;
        step("load_before_sf");
        StallE = 1'b1; FlushE = 1'b1; rand_d();
        step("stall_flush");
        StallE = 1'b0; FlushE = 1'b0; rand_d();
        step("release");

        ValidD = 1'b0; RdD = 5'd0; rand_d(); ValidD = 1'b0;
        step("invalid_load");
        check("invalid_load.cnt", EW'(BubbleCntE), EW'(1));

        FlushE = 1'b1;
        for (int i = 0; i < 20; i++) begin
            rand_d();
            step("flush_sat");
        end
        check("sat.cnt4", EW'(n_BubbleCntE), EW'(15));

        FlushE = 1'b0;
        for (int i = 0; i < 40; i++) begin
            rand_d();
            StallE = ($urandom_range(0, 3) == 0);
            FlushE = ($urandom_range(0, 3) == 0);
            step("random");
        end

        StallE = 1'b1; FlushE = 1'b1; rst = 1'b1; rand_d();
        step("rst_mid");
        check("rst_mid.cnt4", EW'(n_BubbleCntE), EW'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
